knight_rider_ctrl: RTL and testbench

//  Sequencer for the knight-rider LED bank. It generates the shared fade tick and

---
 rtl/knight_rider_ctrl.sv | 120 ++++++++++++
 tb/tb_knight_rider_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_rider_ctrl.sv
// Knight-rider LED sequencer: free-running fade tick and PWM phase, plus a
// one-hot scanner that sweeps back and forth across the fade engines while enabled.
module knight_rider_ctrl #(
    parameter int NUM_LEDS   = 8,
    parameter int TICK_DIV   = 1024,
    parameter int STEP_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                tick,
    output logic [NUM_LEDS-1:0] selected,
    output logic                dir,
    output logic [4:0]          pwm_phase
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam int SW    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_TICKS - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       prescaler;
    logic [POS_W-1:0]    pos, pos_nxt;
    logic [SW-1:0]       step_cnt, step_nxt;
    logic                dir_nxt;
    logic [NUM_LEDS-1:0] selected_nxt;
    logic                adv;

    assign adv = (prescaler == PRE_LAST);

    // Prescaler, tick and PWM phase run regardless of en so fades can complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            tick      <= 1'b0;
            pwm_phase <= '0;
        end else begin
            prescaler <= adv ? '0 : prescaler + PW'(1);
            tick      <= adv;
            pwm_phase <= (pwm_phase == 5'd30) ? 5'd0 : pwm_phase + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos      <= '0;
            step_cnt <= '0;
            dir      <= 1'b0;
            selected <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            step_cnt <= step_nxt;
            dir      <= dir_nxt;
            selected <= selected_nxt;
        end
    end

    // A falling en wins over a coincident adv, so the advanced position never shows.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        step_nxt  = step_cnt;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                pos_nxt  = '0;
                step_nxt = '0;
                dir_nxt  = 1'b0;
                if (en) state_nxt = UP;
            end
            UP, DOWN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    pos_nxt   = '0;
                    step_nxt  = '0;
                    dir_nxt   = 1'b0;
                end else if (adv) begin
                    if (step_cnt == STEP_LAST) begin
                        step_nxt = '0;
                        if (state == UP) begin
                            pos_nxt = pos + POS_W'(1);
                            if (pos_nxt == POS_LAST) begin
                                state_nxt = DOWN;
                                dir_nxt   = 1'b1;
                            end
                        end else begin
                            pos_nxt = pos - POS_W'(1);
                            if (pos_nxt == '0) begin
                                state_nxt = UP;
                                dir_nxt   = 1'b0;
                            end
                        end
                    end else begin
                        step_nxt = step_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = '0;
                step_nxt  = '0;
                dir_nxt   = 1'b0;
            end
        endcase
        selected_nxt = (state_nxt == IDLE) ? '0 : (NUM_LEDS'(1) << pos_nxt);
    end

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Bench for knight_rider_ctrl: a 4-LED/2-step instance and a 2-LED/1-step instance
// share clock, reset and en; a sweep-index model predicts every output each cycle.
module tb_knight_rider_ctrl;

    localparam int TD   = 4;
    localparam int NL_A = 4;
    localparam int ST_A = 2;
    localparam int NL_B = 2;
    localparam int ST_B = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tick_a, dir_a, tick_b, dir_b;
    logic [3:0] sel_a;
    logic [1:0] sel_b;
    logic [4:0] pwm_a, pwm_b;

    int checks = 0;
    int errors = 0;

    knight_rider_ctrl #(.NUM_LEDS(NL_A), .TICK_DIV(TD), .STEP_TICKS(ST_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick_a),
        .selected(sel_a), .dir(dir_a), .pwm_phase(pwm_a)
    );

    knight_rider_ctrl #(.NUM_LEDS(NL_B), .TICK_DIV(TD), .STEP_TICKS(ST_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick_b),
        .selected(sel_b), .dir(dir_b), .pwm_phase(pwm_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: edges since reset, whether scanning, and adv count since scan start.
    int n_m    [2];
    int adv_m  [2];
    bit act_m  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                n_m[i]   <= 0;
                adv_m[i] <= 0;
                act_m[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_m[i] <= n_m[i] + 1;
                if (!en) begin
                    act_m[i] <= 1'b0;
                    adv_m[i] <= 0;
                end else if (!act_m[i]) begin
                    act_m[i] <= 1'b1;
                    adv_m[i] <= 0;
                end else if (n_m[i] % TD == TD - 1) begin
                    adv_m[i] <= adv_m[i] + 1;
                end
            end
        end
    end

    function automatic int sweep_m(input int k, input int nl);
        return k % (2 * nl - 2);
    endfunction

    function automatic int exp_sel(input bit act, input int adv, input int nl, input int st);
        int m;
        m = sweep_m(adv / st, nl);
        if (!act) return 0;
        return 1 << ((m < nl) ? m : (2 * nl - 2 - m));
    endfunction

    function automatic int exp_dir(input bit act, input int adv, input int nl, input int st);
        if (!act) return 0;
        return (sweep_m(adv / st, nl) >= nl - 1) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_eq("tick_a", int'(tick_a), (n_m[0] > 0 && n_m[0] % TD == 0) ? 1 : 0);
            check_eq("pwm_a", int'(pwm_a), n_m[0] % 31);
            check_eq("sel_a", int'(sel_a), exp_sel(act_m[0], adv_m[0], NL_A, ST_A));
            check_eq("dir_a", int'(dir_a), exp_dir(act_m[0], adv_m[0], NL_A, ST_A));
            check_eq("onehot_a", int'($onehot0(sel_a)), 1);
            check_eq("tick_b", int'(tick_b), (n_m[1] > 0 && n_m[1] % TD == 0) ? 1 : 0);
            check_eq("pwm_b", int'(pwm_b), n_m[1] % 31);
            check_eq("sel_b", int'(sel_b), exp_sel(act_m[1], adv_m[1], NL_B, ST_B));
            check_eq("dir_b", int'(dir_b), exp_dir(act_m[1], adv_m[1], NL_B, ST_B));
            check_eq("onehot_b", int'($onehot0(sel_b)), 1);
        end
    end

    initial begin
        logic [7:0] pat;
        int         maxp;
        int         nch;
        int         t_chg[8];
        int         v_chg[8];
        int         d_chg[8];
        int         last;
        bit         found;
        int         exp_v[8];
        int         exp_d[8];

        exp_v = '{1, 2, 4, 8, 4, 2, 1, 2};
        exp_d = '{0, 0, 0, 1, 1, 1, 0, 0};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_sel", int'(sel_a), 0);
        check_eq("rst_tick", int'(tick_a), 0);
        check_eq("rst_pwm", int'(pwm_a), 0);
        check_eq("rst_dir", int'(dir_a), 0);

        // Idle after reset: tick every 4 cycles, pwm_phase wraps 30 -> 0.
        rst_n = 1'b1;
        pat   = '0;
        maxp  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pat = {pat[6:0], tick_a};
            if (int'(pwm_a) > maxp) maxp = int'(pwm_a);
        end
        check_eq("tick_pattern", int'(pat), 8'b0001_0001);
        for (int k = 9; k <= 30; k++) begin
            @(negedge clk);
            if (int'(pwm_a) > maxp) maxp = int'(pwm_a);
        end
        check_eq("pwm_at_30", int'(pwm_a), 30);
        @(negedge clk);
        check_eq("pwm_wrap", int'(pwm_a), 0);
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (int'(pwm_a) > maxp) maxp = int'(pwm_a);
        end
        check_eq("pwm_max", maxp, 30);

        // Enable and follow one full sweep plus one step.
        en = 1'b1;
        @(negedge clk);
        check_eq("first_sel", int'(sel_a), 1);
        nch      = 1;
        v_chg[0] = int'(sel_a);
        d_chg[0] = int'(dir_a);
        t_chg[0] = 0;
        last     = int'(sel_a);
        for (int c = 1; c < 120 && nch < 8; c++) begin
            @(negedge clk);
            if (int'(sel_a) != last) begin
                v_chg[nch] = int'(sel_a);
                d_chg[nch] = int'(dir_a);
                t_chg[nch] = c;
                nch++;
                last = int'(sel_a);
            end
        end
        check_eq("sweep_steps_seen", nch, 8);
        for (int k = 0; k < 8; k++) begin
            if (k < nch) begin
                check_eq("sweep_value", v_chg[k], exp_v[k]);
                check_eq("sweep_dir", d_chg[k], exp_d[k]);
                if (k >= 2) check_eq("sweep_hold", t_chg[k] - t_chg[k-1], 8);
            end
        end

        // Drop en while 0100 is selected, then re-enable.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (sel_a == 4'b0100) found = 1'b1;
        end
        check_eq("wait_0100", int'(found), 1);
        en = 1'b0;
        @(negedge clk);
        check_eq("drop_sel", int'(sel_a), 0);
        check_eq("drop_dir", int'(dir_a), 0);
        repeat (6) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check_eq("reenable_sel", int'(sel_a), 1);

        // Drop en on the very cycle an adv would move the position.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (act_m[0] && (n_m[0] % TD == TD - 1) && ((adv_m[0] + 1) % ST_A == 0))
                found = 1'b1;
        end
        check_eq("wait_adv_move", int'(found), 1);
        en = 1'b0;
        @(negedge clk);
        check_eq("adv_drop_sel", int'(sel_a), 0);
        check_eq("adv_drop_tick", int'(tick_a), 1);

        // Asynchronous reset mid-cycle while scanning.
        en = 1'b1;
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_sel_a", int'(sel_a), 0);
        check_eq("async_sel_b", int'(sel_b), 0);
        check_eq("async_tick", int'(tick_a), 0);
        check_eq("async_dir", int'(dir_a), 0);
        check_eq("async_pwm", int'(pwm_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("restart_sel_a", int'(sel_a), 1);
        check_eq("restart_sel_b", int'(sel_b), 1);

        // Two-LED instance alternates on every tick.
        nch  = 0;
        last = int'(sel_b);
        for (int c = 1; c < 30 && nch < 4; c++) begin
            @(negedge clk);
            if (int'(sel_b) != last) begin
                v_chg[nch] = int'(sel_b);
                t_chg[nch] = c;
                nch++;
                last = int'(sel_b);
            end
        end
        check_eq("alt_steps_seen", nch, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < nch) begin
                check_eq("alt_value", v_chg[k], (k % 2 == 0) ? 2 : 1);
                if (k >= 1) check_eq("alt_hold", t_chg[k] - t_chg[k-1], 4);
            end
        end

        en = 1'b0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
